// File: rtl/fft_pkg.sv
// Shared constants and bundles for the FFT butterfly arithmetic datapath.
package fft_pkg;

    localparam int DATA_W      = 32;
    localparam int GRP_W       = 4;
    localparam int N_GRP       = DATA_W / GRP_W;
    localparam int SCALE_SHIFT = 16;

    localparam logic [DATA_W-1:0] SCALE_0707 = 32'd46341;

    typedef struct packed {
        logic [DATA_W-1:0] sum;
        logic              cout;
        logic [DATA_W-1:0] product;
    } res_t;

endpackage

// File: rtl/carry_look_ahead_32bit.sv
// Two-level carry-lookahead adder/subtractor: 4-bit groups feeding a
// group-level lookahead across all eight groups.
module carry_look_ahead_32bit
    import fft_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              carry_in,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    logic [DATA_W-1:0] bx;
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] p;
    logic [N_GRP-1:0]  grp_g;
    logic [N_GRP-1:0]  grp_p;
    logic [N_GRP:0]    grp_c;

    // Bit and group generate/propagate terms.
    always_comb begin : gp_blk
        logic gg;
        logic pp;
        bx    = carry_in ? ~b : b;
        g     = a & bx;
        p     = a ^ bx;
        grp_g = '0;
        grp_p = '0;
        for (int i = 0; i < N_GRP; i++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int j = GRP_W - 1; j >= 0; j--) begin
                gg = gg | (pp & g[i*GRP_W + j]);
                pp = pp & p[i*GRP_W + j];
            end
            grp_g[i] = gg;
            grp_p[i] = pp;
        end
    end

    // Group carries expanded as sum-of-products from carry_in.
    always_comb begin : grp_c_blk
        logic cc;
        logic pp;
        grp_c    = '0;
        grp_c[0] = carry_in;
        for (int i = 1; i <= N_GRP; i++) begin
            cc = 1'b0;
            pp = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                cc = cc | (pp & grp_g[j]);
                pp = pp & grp_p[j];
            end
            grp_c[i] = cc | (pp & carry_in);
        end
    end

    // Bit carries within each group from its group carry.
    always_comb begin : sum_blk
        logic cc;
        logic pp;
        sum = '0;
        for (int i = 0; i < N_GRP; i++) begin
            for (int k = 0; k < GRP_W; k++) begin
                cc = 1'b0;
                pp = 1'b1;
                for (int j = k - 1; j >= 0; j--) begin
                    cc = cc | (pp & g[i*GRP_W + j]);
                    pp = pp & p[i*GRP_W + j];
                end
                cc = cc | (pp & grp_c[i]);
                sum[i*GRP_W + k] = p[i*GRP_W + k] ^ cc;
            end
        end
    end

    assign cout = grp_c[N_GRP];

endmodule

// File: rtl/complex_mult.sv
// Signed multiply by 0.707 in Q16: shift-add over the set bits of the
// constant, then arithmetic shift right (rounds toward -inf).
module complex_mult
    import fft_pkg::*;
(
    input  logic [DATA_W-1:0] multiplicant,
    output logic [DATA_W-1:0] product
);

    logic signed [2*DATA_W-1:0] ext;
    logic signed [2*DATA_W-1:0] acc;

    always_comb begin
        ext = {{DATA_W{multiplicant[DATA_W-1]}}, multiplicant};
        acc = '0;
        for (int k = 0; k < DATA_W; k++) begin
            if (SCALE_0707[k]) begin
                acc = acc + (ext <<< k);
            end
        end
        product = DATA_W'(acc >>> SCALE_SHIFT);
    end

endmodule

// File: rtl/cla32_const_mult.sv
// Registered BFU arithmetic: CLA add/sub and 0.707 scaler behind
// valid-qualified output registers.
module cla32_const_mult
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              carry_in,
    input  logic [DATA_W-1:0] multiplicant,
    output logic              out_valid,
    output logic [DATA_W-1:0] sum,
    output logic              cout,
    output logic [DATA_W-1:0] product
);

    logic [DATA_W-1:0] sum_w;
    logic              cout_w;
    logic [DATA_W-1:0] prod_w;

    res_t res_d;
    res_t res_q;
    logic valid_d;
    logic valid_q;

    carry_look_ahead_32bit u_cla (
        .a        (a),
        .b        (b),
        .carry_in (carry_in),
        .sum      (sum_w),
        .cout     (cout_w)
    );

    complex_mult u_mult (
        .multiplicant (multiplicant),
        .product      (prod_w)
    );

    // Results hold while no valid operands arrive.
    always_comb begin
        res_d   = res_q;
        valid_d = in_valid;
        if (in_valid) begin
            res_d.sum     = sum_w;
            res_d.cout    = cout_w;
            res_d.product = prod_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign sum       = res_q.sum;
    assign cout      = res_q.cout;
    assign product   = res_q.product;

endmodule

// File: tb/tb_cla32_const_mult.sv
// Self-checking bench for cla32_const_mult: directed cases plus a
// randomized run against an arithmetic reference model.
module tb_cla32_const_mult;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        carry_in;
    logic [31:0] multiplicant;
    logic        out_valid;
    logic [31:0] sum;
    logic        cout;
    logic [31:0] product;

    int pass_cnt;
    int total_cnt;

    cla32_const_mult dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .a            (a),
        .b            (b),
        .carry_in     (carry_in),
        .multiplicant (multiplicant),
        .out_valid    (out_valid),
        .sum          (sum),
        .cout         (cout),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] ref_add(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic        sub
    );
        logic [32:0] r;
        if (!sub) begin
            r = {1'b0, x} + {1'b0, y};
        end else begin
            r[31:0] = x - y;
            r[32]   = (x >= y);
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_mult(input logic [31:0] x);
        longint p;
        p = longint'($signed(x)) * 64'sd46341;
        return 32'(p >>> 16);
    endfunction

    task automatic drive(
        input logic        v,
        input logic [31:0] ai,
        input logic [31:0] bi,
        input logic        ci,
        input logic [31:0] mi
    );
        in_valid     = v;
        a            = ai;
        b            = bi;
        carry_in     = ci;
        multiplicant = mi;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h1234, 32'h55, 1'b0, 32'h7777);
            total_cnt++;
            if ({out_valid, cout, sum, product} !== 66'd0) begin
                $display("FAIL reset%0d: v=%0b c=%0b s=%h p=%h want 0",
                         i, out_valid, cout, sum, product);
            end else pass_cnt++;
        end
        rst = 1'b0;
        drive(1'b1, 32'd5, 32'd3, 1'b0, 32'd1000);
        total_cnt++;
        if (out_valid !== 1'b1 || sum !== 32'd8) begin
            $display("FAIL first_after_reset: v=%0b s=%0d want 1/8",
                     out_valid, sum);
        end else pass_cnt++;
    endtask

    task automatic test_add();
        logic [31:0] ta [2];
        logic [31:0] tb [2];
        logic [31:0] es [2];
        logic        ec [2];
        ta = '{32'd5, 32'hFFFFFFFF};
        tb = '{32'd3, 32'd1};
        es = '{32'd8, 32'd0};
        ec = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, ta[i], tb[i], 1'b0, 32'd0);
            total_cnt++;
            if (sum !== es[i] || cout !== ec[i]) begin
                $display("FAIL add%0d: s=%h c=%0b want %h/%0b",
                         i, sum, cout, es[i], ec[i]);
            end else pass_cnt++;
        end
    endtask

    task automatic test_sub();
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        logic [31:0] es [3];
        logic        ec [3];
        ta = '{32'd3, 32'd5, 32'd0};
        tb = '{32'd5, 32'd5, 32'd100};
        es = '{32'hFFFFFFFE, 32'd0, 32'hFFFFFF9C};
        ec = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ta[i], tb[i], 1'b1, 32'd0);
            total_cnt++;
            if (sum !== es[i] || cout !== ec[i]) begin
                $display("FAIL sub%0d: s=%h c=%0b want %h/%0b",
                         i, sum, cout, es[i], ec[i]);
            end else pass_cnt++;
        end
    endtask

    task automatic test_scale();
        logic [31:0] tm [6];
        logic [31:0] ep [6];
        tm = '{32'd1000, 32'd65536, 32'd100,
               -32'sd100, 32'd0, 32'h80000000};
        ep = '{32'd707, 32'd46341, 32'd70,
               -32'sd71, 32'd0, -32'sd1518501888};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'd0, 32'd0, 1'b0, tm[i]);
            total_cnt++;
            if (product !== ep[i]) begin
                $display("FAIL scale%0d: p=%0d want %0d",
                         i, $signed(product), $signed(ep[i]));
            end else pass_cnt++;
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 32'd10, 32'd20, 1'b0, 32'd2000);
        total_cnt++;
        if (out_valid !== 1'b1 || sum !== 32'd30 ||
            product !== 32'd1414) begin
            $display("FAIL hold_v1: v=%0b s=%0d p=%0d want 1/30/1414",
                     out_valid, sum, product);
        end else pass_cnt++;
        drive(1'b0, 32'd99, 32'd1, 1'b1, 32'd4000);
        total_cnt++;
        if (out_valid !== 1'b0 || sum !== 32'd30 ||
            product !== 32'd1414 || cout !== 1'b0) begin
            $display("FAIL hold_v0: v=%0b s=%0d p=%0d want 0/30/1414",
                     out_valid, sum, product);
        end else pass_cnt++;
        drive(1'b1, 32'd7, 32'd2, 1'b1, 32'd4000);
        total_cnt++;
        if (out_valid !== 1'b1 || sum !== 32'd5 ||
            cout !== 1'b1 || product !== 32'd2828) begin
            $display("FAIL hold_v2: v=%0b s=%0d c=%0b p=%0d",
                     out_valid, sum, cout, product);
        end else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] e_sum;
        logic        e_cout;
        logic [31:0] e_prod;
        logic        e_v;
        logic [32:0] r;
        logic        v;
        logic        ci;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rm;
        e_sum  = sum;
        e_cout = cout;
        e_prod = product;
        for (int i = 0; i < 10000; i++) begin
            v   = ($urandom_range(0, 7) != 0);
            ci  = 1'($urandom);
            ra  = $urandom;
            rb  = (i % 16 == 0) ? ra : $urandom;
            rm  = $urandom;
            rst = (i == 5000 || i == 5001);
            drive(v, ra, rb, ci, rm);
            if (rst) begin
                e_sum  = '0;
                e_cout = 1'b0;
                e_prod = '0;
                e_v    = 1'b0;
            end else begin
                e_v = v;
                if (v) begin
                    r      = ref_add(ra, rb, ci);
                    e_sum  = r[31:0];
                    e_cout = r[32];
                    e_prod = ref_mult(rm);
                end
            end
            total_cnt++;
            if (out_valid !== e_v || sum !== e_sum ||
                cout !== e_cout || product !== e_prod) begin
                $display("FAIL rand%0d: v=%0b s=%h c=%0b p=%h want %0b %h %0b %h",
                         i, out_valid, sum, cout, product,
                         e_v, e_sum, e_cout, e_prod);
            end else pass_cnt++;
        end
        rst = 1'b0;
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        a            = '0;
        b            = '0;
        carry_in     = 1'b0;
        multiplicant = '0;
        test_reset();
        test_add();
        test_sub();
        test_scale();
        test_hold();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
